cordic_gain_comp_pipe: RTL and testbench



---
 rtl/cordic_gain_comp_pipe.sv | 145 ++++++++++++++
 tb/tb_cordic_gain_comp_pipe.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_gain_comp_pipe.sv
`default_nettype none
// ============================================================================
// cordic_gain_comp_pipe: 2-stage valid/ready CORDIC gain compensation of one
// H row plus y sample, with round-half-up, saturation and frame-row marking.
// Rev 1.0
// ============================================================================
module cordic_gain_comp_pipe #(
  parameter int WL   = 16,
  parameter int N    = 4,
  parameter int ROWS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WL*N-1:0] in_hx,
  input  logic [WL*N-1:0] in_hy,
  input  logic [WL-1:0]   in_yx,
  input  logic [WL-1:0]   in_yy,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WL*N-1:0] out_hx,
  output logic [WL*N-1:0] out_hy,
  output logic [WL-1:0]   out_yx,
  output logic [WL-1:0]   out_yy,
  output logic            out_sat,
  output logic            out_last
);

  localparam int LANES = 2*N + 2;
  localparam int PW    = WL + 18;
  localparam int CW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Bypass reuses the multiplier with a unity coefficient (1.0 in Q2.15).
  localparam logic signed [17:0]   c_coef_unity  = 18'sd32768;
  localparam logic signed [17:0]   c_coef_inv_k  = 18'sd19898;
  localparam logic signed [17:0]   c_coef_inv_k2 = 18'sd12083;
  localparam logic signed [17:0]   c_coef_k      = 18'sd53961;
  localparam logic signed [PW-1:0] c_half        = PW'(16384);
  localparam logic signed [PW-1:0] c_max         = PW'((2**(WL-1)) - 1);
  localparam logic signed [PW-1:0] c_min         = PW'(-(2**(WL-1)));
  localparam logic [CW-1:0]        c_last_row    = CW'(ROWS - 1);

  logic signed [WL-1:0] w_lane   [LANES];
  logic signed [PW-1:0] w_prod   [LANES];
  logic signed [PW-1:0] r_prod   [LANES];
  logic        [WL-1:0] w_res    [LANES];
  logic        [WL-1:0] r_res    [LANES];
  logic [LANES-1:0]     w_lane_sat;
  logic signed [17:0]   w_coef;
  logic [1:0]           r_mode;
  logic                 r_v1;
  logic                 r_v2;
  logic                 r_sat;
  logic                 r_last;
  logic                 w_en1;
  logic                 w_en2;
  logic                 w_out_fire;
  logic [CW-1:0]        r_row_cnt;
  logic [CW-1:0]        w_row_next;
  logic [CW-1:0]        w_row_in;

  for (genvar gi = 0; gi < N; gi++) begin : g_h_lanes
    assign w_lane[gi]          = in_hx[WL*gi +: WL];
    assign w_lane[N+gi]        = in_hy[WL*gi +: WL];
    assign out_hx[WL*gi +: WL] = r_res[gi];
    assign out_hy[WL*gi +: WL] = r_res[N+gi];
  end
  assign w_lane[2*N]   = in_yx;
  assign w_lane[2*N+1] = in_yy;
  assign out_yx        = r_res[2*N];
  assign out_yy        = r_res[2*N+1];

  always_comb begin
    w_coef = c_coef_unity;
    case (in_mode)
      2'd1:    w_coef = c_coef_inv_k;
      2'd2:    w_coef = c_coef_inv_k2;
      2'd3:    w_coef = c_coef_k;
      default: w_coef = c_coef_unity;
    endcase
  end

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lanes
    logic signed [PW-1:0] w_sum;
    logic signed [PW-1:0] w_rnd;
    logic                 w_hi;
    logic                 w_lo;

    assign w_prod[gl]     = PW'(w_lane[gl]) * PW'(w_coef);
    assign w_sum          = r_prod[gl] + c_half;
    assign w_rnd          = w_sum >>> 15;
    assign w_hi           = (w_rnd > c_max);
    assign w_lo           = (w_rnd < c_min);
    assign w_lane_sat[gl] = w_hi | w_lo;
    assign w_res[gl]      = w_hi ? c_max[WL-1:0] : (w_lo ? c_min[WL-1:0] : w_rnd[WL-1:0]);
  end

  assign w_en2      = !r_v2 || out_ready;
  assign w_en1      = !r_v1 || w_en2;
  assign in_ready   = w_en1;
  assign out_valid  = r_v2;
  assign out_sat    = r_sat;
  assign out_last   = r_last;
  assign w_out_fire = r_v2 && out_ready;

  // A beat entering stage 2 while the current one leaves takes the next row.
  assign w_row_next = (r_row_cnt == c_last_row) ? '0 : r_row_cnt + CW'(1);
  assign w_row_in   = w_out_fire ? w_row_next : r_row_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_mode    <= 2'd0;
      r_sat     <= 1'b0;
      r_last    <= 1'b0;
      r_row_cnt <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_prod[i] <= '0;
        r_res[i]  <= '0;
      end
    end else begin
      if (w_en1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_mode <= in_mode;
          for (int i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
        end
      end
      if (w_en2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          for (int i = 0; i < LANES; i++) r_res[i] <= w_res[i];
          r_sat  <= (r_mode != 2'd0) && (|w_lane_sat);
          r_last <= (w_row_in == c_last_row);
        end
      end
      if (w_out_fire) r_row_cnt <= w_row_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_gain_comp_pipe.sv
`default_nettype none
// ============================================================================
// tb_cordic_gain_comp_pipe: scoreboard bench for cordic_gain_comp_pipe.
// Rev 1.0
// ============================================================================
module tb_cordic_gain_comp_pipe;

  localparam int WL   = 16;
  localparam int N    = 4;
  localparam int ROWS = 4;

  typedef struct packed {
    logic [WL*N-1:0] hx;
    logic [WL*N-1:0] hy;
    logic [WL-1:0]   yx;
    logic [WL-1:0]   yy;
    logic [1:0]      mode;
  } beat_t;

  typedef struct packed {
    logic [WL*N-1:0] hx;
    logic [WL*N-1:0] hy;
    logic [WL-1:0]   yx;
    logic [WL-1:0]   yy;
    logic            sat;
    logic            last;
  } res_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [WL*N-1:0] in_hx;
  logic [WL*N-1:0] in_hy;
  logic [WL-1:0]   in_yx;
  logic [WL-1:0]   in_yy;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [WL*N-1:0] out_hx;
  logic [WL*N-1:0] out_hy;
  logic [WL-1:0]   out_yx;
  logic [WL-1:0]   out_yy;
  logic            out_sat;
  logic            out_last;

  res_t q[$];
  int   push_idx = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  cordic_gain_comp_pipe #(.WL(WL), .N(N), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_hx(in_hx), .in_hy(in_hy), .in_yx(in_yx), .in_yy(in_yy), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hx(out_hx), .out_hy(out_hy), .out_yx(out_yx), .out_yy(out_yy),
    .out_sat(out_sat), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference lane arithmetic: {saturated, value}
  function automatic logic [WL:0] lane_model(input logic [WL-1:0] x, input logic [1:0] m);
    longint c;
    longint r;
    if (m == 2'd0) return {1'b0, x};
    c = (m == 2'd1) ? 64'sd19898 : ((m == 2'd2) ? 64'sd12083 : 64'sd53961);
    r = ((longint'($signed(x)) * c) + 64'sd16384) >>> 15;
    if (r > 64'sd32767)  return {1'b1, 16'h7fff};
    if (r < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, r[WL-1:0]};
  endfunction

  function automatic res_t model(input beat_t b, input logic last);
    res_t e;
    logic [WL:0] t;
    e = '0;
    for (int i = 0; i < N; i++) begin
      t = lane_model(b.hx[WL*i +: WL], b.mode);
      e.hx[WL*i +: WL] = t[WL-1:0];
      e.sat = e.sat | t[WL];
      t = lane_model(b.hy[WL*i +: WL], b.mode);
      e.hy[WL*i +: WL] = t[WL-1:0];
      e.sat = e.sat | t[WL];
    end
    t = lane_model(b.yx, b.mode);
    e.yx = t[WL-1:0];
    e.sat = e.sat | t[WL];
    t = lane_model(b.yy, b.mode);
    e.yy = t[WL-1:0];
    e.sat = e.sat | t[WL];
    e.last = last;
    return e;
  endfunction

  function automatic beat_t make_beat(input logic [WL-1:0] v, input logic [1:0] m);
    beat_t b;
    b.hx = {N{v}};
    b.hy = {N{v}};
    b.yx = v;
    b.yy = v;
    b.mode = m;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.hx[WL*i +: WL] = WL'($urandom);
      b.hy[WL*i +: WL] = WL'($urandom);
    end
    b.yx = WL'($urandom);
    b.yy = WL'($urandom);
    b.mode = 2'($urandom_range(0, 3));
    return b;
  endfunction

  // One clock: drive at negedge, sample 1 ns later, push expected on acceptance.
  task automatic run_cycle(input logic iv, input beat_t b, input logic ordy,
                           output logic ir, output logic ov, output res_t ob);
    in_valid = iv;
    {in_hx, in_hy, in_yx, in_yy, in_mode} = b;
    out_ready = ordy;
    #1;
    ir = in_ready;
    ov = out_valid;
    ob = {out_hx, out_hy, out_yx, out_yy, out_sat, out_last};
    if (iv && ir) begin
      q.push_back(model(b, (push_idx % ROWS) == ROWS - 1));
      push_idx++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_single(input beat_t b, output logic ir, output logic ov_early,
                             output logic ov, output res_t ob);
    logic d;
    res_t x;
    run_cycle(1'b1, b, 1'b1, ir, d, x);
    run_cycle(1'b0, b, 1'b1, d, ov_early, x);
    run_cycle(1'b0, b, 1'b1, d, ov, ob);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    push_idx = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if ({out_hx, out_hy, out_yx, out_yy, out_sat, out_last} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {out_hx, out_hy, out_yx, out_yy, out_sat, out_last});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mode_scaling();
    logic [1:0]    ms [3] = '{2'd1, 2'd2, 2'd3};
    logic [WL-1:0] vi [3] = '{16'sd16384, -16'sd16384, 16'sd16384};
    logic [WL-1:0] vo [3] = '{16'sd9949, -16'sd6041, 16'sd26981};
    logic ir, ove, ov;
    res_t ob, e;
    for (int k = 0; k < 3; k++) begin
      send_single(make_beat(vi[k], ms[k]), ir, ove, ov, ob);
      n_checks++;
      if (ir !== 1'b1) $display("FAIL scale_accept m%0d: got %b want 1", ms[k], ir);
      else n_pass++;
      n_checks++;
      if (ove !== 1'b0) $display("FAIL scale_latency_early m%0d: got %b want 0", ms[k], ove);
      else n_pass++;
      n_checks++;
      if (ov !== 1'b1) $display("FAIL scale_latency m%0d: got %b want 1", ms[k], ov);
      else n_pass++;
      n_checks++;
      if ({ob.hx, ob.hy, ob.yx, ob.yy, ob.sat} !== {{N{vo[k]}}, {N{vo[k]}}, vo[k], vo[k], 1'b0})
        $display("FAIL scale_value m%0d: got %h want lanes %h sat 0", ms[k], {ob.hx, ob.hy, ob.yx, ob.yy, ob.sat}, vo[k]);
      else n_pass++;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_checks++;
        if (ob !== e) $display("FAIL scale_scoreboard m%0d: got %h want %h", ms[k], ob, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] ms [2] = '{2'd3, 2'd0};
    logic ir, ove, ov;
    beat_t b;
    res_t ob, e;
    for (int k = 0; k < 2; k++) begin
      b.hx = {N{16'h7fff}};
      b.hy = {N{16'h8000}};
      b.yx = 16'h7fff;
      b.yy = 16'h8000;
      b.mode = ms[k];
      send_single(b, ir, ove, ov, ob);
      n_checks++;
      if (ov !== 1'b1) $display("FAIL sat_valid m%0d: got %b want 1", ms[k], ov);
      else n_pass++;
      n_checks++;
      if ({ob.hx, ob.hy, ob.yx, ob.yy} !== {b.hx, b.hy, b.yx, b.yy})
        $display("FAIL sat_value m%0d: got %h want %h", ms[k], {ob.hx, ob.hy, ob.yx, ob.yy}, {b.hx, b.hy, b.yx, b.yy});
      else n_pass++;
      n_checks++;
      if (ob.sat !== (k == 0)) $display("FAIL sat_flag m%0d: got %b want %b", ms[k], ob.sat, (k == 0));
      else n_pass++;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_checks++;
        if (ob !== e) $display("FAIL sat_scoreboard m%0d: got %h want %h", ms[k], ob, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [1:0]    ms [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [WL-1:0] ev [5] = '{16'd8192, 16'd4975, 16'd3021, 16'd13490, 16'd4975};
    int sent = 0, got = 0, cyc = 0, first = -1, lastc = 0;
    logic ir, ov;
    beat_t b;
    res_t ob, e;
    while ((sent < 5 || q.size() != 0) && cyc < 50) begin
      b = '0;
      if (sent < 5) b = make_beat(16'd8192, ms[sent]);
      run_cycle(sent < 5, b, 1'b1, ir, ov, ob);
      if (sent < 5 && ir) sent++;
      if (ov) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        n_checks++;
        if (q.size() == 0) $display("FAIL switch_unexpected_output: got %h want none", ob);
        else begin
          e = q.pop_front();
          if (ob !== e) $display("FAIL switch_scoreboard: got %h want %h", ob, e);
          else n_pass++;
        end
        if (got < 5) begin
          n_checks++;
          if (ob.hx[WL-1:0] !== ev[got]) $display("FAIL switch_value beat%0d: got %0d want %0d", got, ob.hx[WL-1:0], ev[got]);
          else n_pass++;
        end
        got++;
      end
      cyc++;
    end
    n_checks++;
    if (got !== 5) $display("FAIL switch_count: got %0d want 5", got);
    else n_pass++;
    n_checks++;
    if (lastc - first !== 4) $display("FAIL switch_throughput: got span %0d want 4", lastc - first);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    logic [3:0] pat = 4'b1001;
    beat_t bs [10];
    int sent = 0, got = 0, cyc = 0, occ;
    logic ir, ov, ordy, pov = 1'b0, pordy = 1'b1;
    beat_t b;
    res_t ob, pob = '0, e;
    for (int i = 0; i < 10; i++) bs[i] = rand_beat();
    while ((sent < 10 || q.size() != 0) && cyc < 200) begin
      ordy = pat[cyc % 4];
      occ = q.size();
      b = '0;
      if (sent < 10) b = bs[sent];
      run_cycle(sent < 10, b, ordy, ir, ov, ob);
      n_checks++;
      if (ir !== !(occ == 2 && !ordy)) $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, ir, !(occ == 2 && !ordy));
      else n_pass++;
      if (pov && !pordy) begin
        n_checks++;
        if (ov !== 1'b1 || ob !== pob) $display("FAIL bp_stall_stable cyc%0d: got %b/%h want 1/%h", cyc, ov, ob, pob);
        else n_pass++;
      end
      if (sent < 10 && ir) sent++;
      if (ov && ordy) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL bp_unexpected_output: got %h want none", ob);
        else begin
          e = q.pop_front();
          if (ob !== e) $display("FAIL bp_scoreboard beat%0d: got %h want %h", got, ob, e);
          else n_pass++;
        end
        got++;
      end
      pov = ov;
      pordy = ordy;
      pob = ob;
      cyc++;
    end
    n_checks++;
    if (got !== 10) $display("FAIL bp_count: got %0d want 10", got);
    else n_pass++;
  endtask

  task automatic test_frame();
    logic [3:0] pat = 4'b1001;
    for (int pass = 0; pass < 2; pass++) begin
      int sent = 0, got = 0, cyc = 0;
      logic [8:0] lmask = '0;
      logic ir, ov, ordy;
      beat_t b;
      res_t ob, e;
      reset_dut();
      while ((sent < 9 || q.size() != 0) && cyc < 200) begin
        ordy = (pass == 0) ? 1'b1 : pat[cyc % 4];
        b = rand_beat();
        run_cycle(sent < 9, b, ordy, ir, ov, ob);
        if (sent < 9 && ir) sent++;
        if (ov && ordy) begin
          n_checks++;
          if (q.size() == 0) $display("FAIL frame_unexpected_output: got %h want none", ob);
          else begin
            e = q.pop_front();
            if (ob !== e) $display("FAIL frame_scoreboard p%0d beat%0d: got %h want %h", pass, got, ob, e);
            else n_pass++;
          end
          if (got < 9) lmask[got] = ob.last;
          got++;
        end
        cyc++;
      end
      n_checks++;
      if (lmask !== 9'b010001000) $display("FAIL frame_last_mask p%0d: got %b want 010001000", pass, lmask);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int sent = 0, got = 0, cyc = 0;
    logic [3:0] lmask = '0;
    logic ir, ov;
    beat_t b;
    res_t ob, e;
    reset_dut();
    b = rand_beat();
    while (got < 2 && cyc < 50) begin
      run_cycle(sent < 2, b, 1'b1, ir, ov, ob);
      if (sent < 2 && ir) begin sent++; b = rand_beat(); end
      if (ov) begin
        void'(q.pop_front());
        got++;
      end
      cyc++;
    end
    sent = 0;
    cyc = 0;
    while (sent < 2 && cyc < 20) begin
      run_cycle(1'b1, b, 1'b0, ir, ov, ob);
      if (ir) begin sent++; b = rand_beat(); end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL rmid_full: got ready %b valid %b want 0 1", in_ready, out_valid);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    push_idx = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rmid_flags: got valid %b ready %b want 0 1", out_valid, in_ready);
    else n_pass++;
    n_checks++;
    if ({out_hx, out_hy, out_yx, out_yy, out_sat, out_last} !== '0)
      $display("FAIL rmid_outputs: got %h want 0", {out_hx, out_hy, out_yx, out_yy, out_sat, out_last});
    else n_pass++;
    sent = 0;
    got = 0;
    cyc = 0;
    while ((sent < 4 || q.size() != 0) && cyc < 50) begin
      b = rand_beat();
      run_cycle(sent < 4, b, 1'b1, ir, ov, ob);
      if (sent < 4 && ir) sent++;
      if (ov) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL rmid_unexpected_output: got %h want none", ob);
        else begin
          e = q.pop_front();
          if (ob !== e) $display("FAIL rmid_scoreboard beat%0d: got %h want %h", got, ob, e);
          else n_pass++;
        end
        if (got < 4) lmask[got] = ob.last;
        got++;
      end
      cyc++;
    end
    n_checks++;
    if (lmask !== 4'b1000) $display("FAIL rmid_last_mask: got %b want 1000", lmask);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_hx = '0;
    in_hy = '0;
    in_yx = '0;
    in_yy = '0;
    in_mode = 2'd0;
    test_reset();
    test_mode_scaling();
    test_saturation();
    test_mode_switch();
    test_back_pressure();
    test_frame();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
